// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory bus arbiter.
// The watchdog feature of mem_bus_arbiter is enabled by MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2,
    DRAIN   = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request after 'last',
// wrapping modulo N; returns a one-hot winner and a valid flag.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  int               cand_i;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt    = '0;
    valid  = 1'b0;
    cand_i = 0;
    cand   = '0;
    for (int off = 1; off <= N; off++) begin
      cand_i = (int'(last) + off) % N;
      cand   = cand_i[IDX_W-1:0];
      if (!valid && req[cand]) begin
        gnt[cand] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port slave among NUM_MASTERS masters.
// Optional ISSUE watchdog (with m_err port) is enabled by MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr_en,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [DATA_W-1:0]             m_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic [NUM_MASTERS-1:0]        m_err,
`endif
  output logic                          s_req,
  output logic                          s_wr_en,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_gnt,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    dbg_state
);

  // Handshake: a master holds m_req and its command stable until it sees its
  // one-cycle m_gnt pulse; the slave completes when s_gnt is sampled high
  // while s_req is high, and s_gnt must fall again before the next command.
  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                s_req_q, s_req_d;
  logic                s_wr_en_q, s_wr_en_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [NUM_MASTERS-1:0] m_gnt_q, m_gnt_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
`endif

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  rr_picker #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_picker (
    .req   (m_req),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    s_req_d   = s_req_q;
    s_wr_en_d = s_wr_en_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_gnt_d   = '0;
    m_rdata_d = m_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    m_err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d     = pick_idx;
          last_d    = pick_idx;
          s_req_d   = 1'b1;
          s_wr_en_d = m_wr_en[pick_idx];
          s_addr_d  = m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          s_wdata_d = m_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          state_d   = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ISSUE: begin
        if (s_gnt) begin
          m_rdata_d      = s_rdata;
          m_gnt_d[idx_q] = 1'b1;
          s_req_d        = 1'b0;
          state_d        = RESPOND;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Give up on a silent slave: complete with an error and zero data.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          m_rdata_d      = '0;
          m_gnt_d[idx_q] = 1'b1;
          m_err_d[idx_q] = 1'b1;
          s_req_d        = 1'b0;
          state_d        = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESPOND: state_d = DRAIN;
      DRAIN: begin
        // A lingering s_gnt must not complete the next transaction.
        if (!s_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      idx_q     <= '0;
      s_req_q   <= 1'b0;
      s_wr_en_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_gnt_q   <= '0;
      m_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      m_err_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      s_req_q   <= s_req_d;
      s_wr_en_q <= s_wr_en_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_gnt_q   <= m_gnt_d;
      m_rdata_q <= m_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

  assign s_req     = s_req_q;
  assign s_wr_en   = s_wr_en_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign m_gnt     = m_gnt_q;
  assign m_rdata   = m_rdata_q;
  assign dbg_state = state_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign m_err     = m_err_q;
`endif

endmodule
